cache_mem_responder: RTL and testbench
======================================

Name: cache_mem_responder

Overview:
- Responder end of the cache-to-memory request protocol. Serves the icache read port and the dcache read/write port through a single RAM port.
- Each cache holds REN/WEN/addr/store stable while its wait is high. This block completes a request by pulling that wait low for exactly one cycle, with load data valid in that cycle.
- Sits between the caches and the RAM model. It arbitrates between the two caches and guards against a RAM that never answers.

Parameters:
- TIMEOUT, 16: number of SERVE cycles with ramready low before a forced completion; 0 disables the timeout.
- ERR_DATA, 32'hBAD0BAD0: load value returned on a forced completion.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  32  icache address.
- iwait  out  1  icache wait; low for one cycle on completion.
- iload  out  32  icache read data; valid when iwait is low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache wait; low for one cycle on completion.
- dload  out  32  dcache read data; valid when dwait is low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramready  in  1  RAM access complete in this cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (RST high at a posedge): state=IDLE, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, err=0, timeout counter=0, last-grant=icache. RST wins over any in-flight access; a completion pending in that cycle is dropped.
- States: IDLE, DSERV, ISERV.
- IDLE:
  - All RAM strobes are 0 and both waits are 1.
  - If dcache requests (dREN|dWEN), go to DSERV; else if iREN, go to ISERV.
  - The grant is registered: one cycle from request to RAM strobe.
- DSERV:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN, then ramWEN=1 and ramREN=0 (write wins when both are set). Else ramREN=1.
  - The RAM signals are combinational from the live cache inputs.
- ISERV: ramREN=1, ramaddr=iaddr, ramWEN=0, ramstore=0.
- Completion (in a SERVE state with ramready=1):
  - The granted port's wait goes low in that same cycle, and its load is driven with ramload (0 for writes).
  - Next state is IDLE, which gives a guaranteed one-cycle bubble between accesses.
  - The non-granted port's wait stays 1.
- Minimum latency: request asserted at cycle 0, strobe at cycle 1, wait low at cycle 1 if ramready is already high.
- Abort: if the granted port drops all of its request bits while in SERVE:
  - RAM strobes go to 0 in the same cycle and the next state is IDLE.
  - Its wait is not pulsed low, and the timeout counter is cleared.
- Timeout:
  - The counter clears on SERVE entry and increments on each SERVE cycle with ramready=0.
  - When TIMEOUT>0 and the counter reaches TIMEOUT: force completion (wait low one cycle, load=ERR_DATA, RAM strobes 0 in that cycle), set err, go to IDLE.
  - err stays set until RST.
  - Counter width is clog2(TIMEOUT+1); it saturates and never wraps.
- Simultaneous requests: the policy applies only in IDLE. A request arriving during SERVE waits; its wait stays high.
- iload/dload hold 0 whenever the corresponding wait is high.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register updates on every completion (normal or forced, not abort).
  - When both caches request in IDLE, grant the port not granted last. A single requester is always granted.
- Undefined: fixed priority, dcache always wins. The last-grant register is not built.

Test Plan:
- Reset: hold RST 2 cycles with dREN=1 → dwait=iwait=1, ramREN=ramWEN=0, err=0, dload=0; first strobe appears one cycle after RST falls.
- dcache read: daddr=0x100, ramready after 3 DSERV cycles with ramload=0xDEADBEEF → ramREN=1 and ramaddr=0x100 for 3 cycles; dwait low for exactly 1 cycle with dload=0xDEADBEEF; next cycle is IDLE.
- Contention: iREN iaddr=0x0 and dWEN daddr=0x3100 dstore=0x5 asserted together, ramready=1 → without macro: dcache first (ramWEN=1, ramstore=0x5), then bubble, then icache read. With ARB_ROUND_ROBIN_EN after a prior dcache grant: icache served first.
- Timeout: TIMEOUT=8, ramready held 0, dREN=1 → after 8 DSERV cycles, dwait low for 1 cycle with dload=0xBAD0BAD0; err=1 and stays 1 through later normal accesses until RST.
- Abort: dREN drops in the 2nd DSERV cycle → ramREN=0 in that same cycle, dwait never low, state IDLE next; a following iREN is served normally.
- Reset mid-access: RST in a DSERV cycle where ramready=1 → no dwait low pulse, all outputs at reset values next cycle.

Source files
------------

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: serves icache reads and dcache reads/writes through one RAM port, with a RAM-hang timeout
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   iREN, iaddr -> iwait, iload    icache read request / completion
//   dREN, dWEN, daddr, dstore      dcache request (held stable while dwait is high)
//   dwait, dload                   dcache completion (wait low one cycle, load valid then)
//   ramREN, ramWEN, ramaddr, ramstore, ramload, ramready   single RAM port
//   err                            sticky timeout flag, cleared only by RST
// Optional: ARB_ROUND_ROBIN_EN gives round-robin arbitration when both caches request; otherwise the dcache always wins.
module cache_mem_responder #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hBAD0BAD0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    localparam bit TO_EN = TIMEOUT > 0;

    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          dreq, sd, si, serve, greq, abort, tmo, done, fin, pick_d;

    assign dreq  = dREN | dWEN;
    assign sd    = state_q == DSERV;
    assign si    = state_q == ISERV;
    assign serve = sd | si;
    assign greq  = sd ? dreq : iREN;
    assign abort = serve & ~greq;
    assign tmo   = TO_EN && serve && greq && cnt_q == TMAX;
    assign done  = serve & greq & ~tmo & ramready;
    // A completion falling in a reset cycle is dropped.
    assign fin   = (tmo | done) & ~RST;
    assign err   = err_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;  // 1: dcache was granted last

    assign pick_d = dreq & (~iREN | ~last_q);
    assign last_d = fin ? sd : last_q;

    always_ff @(posedge CLK) begin
        last_q <= RST ? 1'b0 : last_d;
    end
`else
    assign pick_d = dreq;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q | tmo;
        // Held at zero outside SERVE so every grant starts a fresh count; saturates instead of wrapping.
        cnt_d   = !serve ? '0 : (!ramready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        if (state_q == IDLE)
            state_d = pick_d ? DSERV : iREN ? ISERV : IDLE;
        else if (!serve || abort || tmo || done)
            state_d = IDLE;
    end

    always_comb begin
        ramREN   = serve & greq & ~tmo & (si | ~dWEN);
        ramWEN   = sd & dWEN & ~tmo;
        ramaddr  = sd ? daddr : si ? iaddr : '0;
        ramstore = sd ? dstore : '0;
        dwait    = ~(fin & sd);
        iwait    = ~(fin & si);
        dload    = (fin & sd) ? (tmo ? ERR_DATA : dWEN ? '0 : ramload) : '0;
        iload    = (fin & si) ? (tmo ? ERR_DATA : ramload) : '0;
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: scoreboard bench for cache_mem_responder (TIMEOUT=8)
module tb_cache_mem_responder;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ramready = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int          total = 0, bad = 0, ncomp = 0, ecomp = 0;
    logic [31:0] dq[$], iq[$];
    bit          oq[$];

    always #5 CLK = ~CLK;

    cache_mem_responder #(.TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_done(input bit is_d, input logic [31:0] v);
        oq.push_back(is_d);
        if (is_d) dq.push_back(v);
        else iq.push_back(v);
        ecomp++;
    endtask

    task automatic wait_done(input int lim);
        for (int k = 0; k < lim && ncomp < ecomp; k++) cyc();
        if (ncomp < ecomp) check("wait_bound", ncomp, ecomp);
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (dwait === 1'b0 && iwait === 1'b0) begin
                check("both_done", 1, 0);
            end else if (dwait === 1'b0 || iwait === 1'b0) begin
                ncomp++;
                if (oq.size() == 0) check("unexp_done", 1, 0);
                else check("order", dwait === 1'b0, oq.pop_front());
                if (dwait === 1'b0) begin
                    if (dq.size() == 0) check("d_unexp", 1, 0);
                    else check("dload", dload, dq.pop_front());
                end else begin
                    if (iq.size() == 0) check("i_unexp", 1, 0);
                    else check("iload", iload, iq.pop_front());
                end
            end
            if (dwait === 1'b1) check("dload_hold", dload, 0);
            if (iwait === 1'b1) check("iload_hold", iload, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // reset held two cycles with a dcache request pending
        dREN = 1'b1; daddr = 32'h80;
        cyc(); cyc();
        @(negedge CLK);
        check("rst_dwait", dwait, 1);
        check("rst_iwait", iwait, 1);
        check("rst_ren", ramREN, 0);
        check("rst_wen", ramWEN, 0);
        check("rst_err", err, 0);
        check("rst_dload", dload, 0);
        cyc(); RST = 1'b0;
        @(negedge CLK) check("strobe_early", ramREN, 0);
        cyc();
        @(negedge CLK);
        check("first_ren", ramREN, 1);
        check("first_addr", ramaddr, 32'h80);
        // abort in the second DSERV cycle
        cyc(); dREN = 1'b0;
        @(negedge CLK);
        check("abort_ren", ramREN, 0);
        check("abort_dwait", dwait, 1);
        cyc();
        @(negedge CLK) check("abort_idle", ramREN, 0);
        iREN = 1'b1; iaddr = 32'h40; ramready = 1'b1; ramload = 32'h11111111;
        expect_done(0, 32'h11111111);
        wait_done(10);
        iREN = 1'b0; ramready = 1'b0;
        // dcache read with 3 wait cycles
        dREN = 1'b1; daddr = 32'h100;
        @(negedge CLK) check("rd_idle", ramREN, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge CLK);
            check("rd_ren", ramREN, 1);
            check("rd_addr", ramaddr, 32'h100);
            check("rd_wait", dwait, 1);
        end
        cyc(); ramready = 1'b1; ramload = 32'hDEADBEEF;
        expect_done(1, 32'hDEADBEEF);
        @(negedge CLK) check("rd_ren4", ramREN, 1);
        cyc(); dREN = 1'b0; ramready = 1'b0;
        check("rd_cnt", ncomp, ecomp);
        @(negedge CLK);
        check("rd_bubble_wait", dwait, 1);
        check("rd_bubble_ren", ramREN, 0);
        // contention: icache read vs dcache write
        iREN = 1'b1; iaddr = 32'h0; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h5;
        ramready = 1'b1; ramload = 32'h22222222;
`ifdef ARB_ROUND_ROBIN_EN
        expect_done(0, 32'h22222222);
        expect_done(1, 32'h0);
`else
        expect_done(1, 32'h0);
        expect_done(0, 32'h22222222);
`endif
        cyc();
        @(negedge CLK);
`ifdef ARB_ROUND_ROBIN_EN
        check("ct1_ren", ramREN, 1);
        check("ct1_addr", ramaddr, 32'h0);
`else
        check("ct1_wen", ramWEN, 1);
        check("ct1_ren", ramREN, 0);
        check("ct1_store", ramstore, 32'h5);
        check("ct1_addr", ramaddr, 32'h3100);
`endif
        cyc();
`ifdef ARB_ROUND_ROBIN_EN
        iREN = 1'b0;
`else
        dWEN = 1'b0;
`endif
        @(negedge CLK) check("ct_bubble", {ramREN, ramWEN}, 0);
        cyc();
        @(negedge CLK);
`ifdef ARB_ROUND_ROBIN_EN
        check("ct2_wen", ramWEN, 1);
        check("ct2_store", ramstore, 32'h5);
`else
        check("ct2_ren", ramREN, 1);
        check("ct2_addr", ramaddr, 32'h0);
`endif
        cyc(); iREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
        check("ct_cnt", ncomp, ecomp);
        // timeout: RAM never answers
        dREN = 1'b1; daddr = 32'h200;
        expect_done(1, 32'hBAD0BAD0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            @(negedge CLK);
            check("to_wait", dwait, 1);
            check("to_ren", ramREN, 1);
        end
        cyc();
        @(negedge CLK);
        check("to_ren0", ramREN, 0);
        check("to_err_pre", err, 0);
        cyc(); dREN = 1'b0;
        check("to_cnt", ncomp, ecomp);
        @(negedge CLK) check("err_set", err, 1);
        iREN = 1'b1; iaddr = 32'h44; ramready = 1'b1; ramload = 32'h33333333;
        expect_done(0, 32'h33333333);
        wait_done(10);
        iREN = 1'b0; ramready = 1'b0;
        @(negedge CLK) check("err_hold", err, 1);
        // reset in a DSERV cycle with ramready high
        cyc(); dREN = 1'b1; daddr = 32'h300;
        cyc();
        @(negedge CLK) check("rm_ren", ramREN, 1);
        RST = 1'b1; ramready = 1'b1; ramload = 32'h44444444;
        #1 check("rm_nopulse", dwait, 1);
        cyc(); RST = 1'b0; dREN = 1'b0; ramready = 1'b0;
        @(negedge CLK);
        check("rm_wait", dwait, 1);
        check("rm_ren0", ramREN, 0);
        check("rm_err", err, 0);
        check("rm_dload", dload, 0);
        check("rm_addr", ramaddr, 0);
        check("sb_empty", oq.size() + dq.size() + iq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
